mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single four-banked main memory between the instruction-cache controller (port 0) and the data-cache controller (port 1).
- Grants one controller ownership for a whole transaction: a 4-word fill, a write-back, or a mixed sequence.
- Forwards that controller's mem_rd/mem_wr/addr/data to memory and routes returned read data back to it.
- Tracks in-flight reads and hands over ownership only when the read pipeline has drained.

Parameters:
- MEM_LAT, 2: fixed cycles from mem_rd issue to valid mem_dout (legal range 1..4).
- AW, 16: address width.
- DW, 16: data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- req0  in  1  port 0 requests or holds ownership
- rd0  in  1  port 0 read strobe
- wr0  in  1  port 0 write strobe
- addr0  in  AW  port 0 address
- din0  in  DW  port 0 write data
- gnt0  out  1  port 0 owns memory
- dout0  out  DW  read data to port 0
- dvalid0  out  1  dout0 valid this cycle
- req1, rd1, wr1, addr1, din1, gnt1, dout1, dvalid1: same as port 0, for port 1
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_din  out  DW  memory write data
- mem_dout  in  DW  memory read data
- err  out  1  sticky protocol error

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE; gnt0=gnt1=0; err=0.
  - Read-tag pipeline cleared; rr_last=1, so port 0 wins the first tie.
  - mem_rd=mem_wr=0; dvalid0=dvalid1=0; dout0=dout1=0; mem_addr=mem_din=0.
  - Reads in flight at reset are discarded and never delivered.
- States: IDLE, OWN0, OWN1, DRAIN, ERROR. gnt0=(state==OWN0), gnt1=(state==OWN1); both are registered.
- IDLE:
  - Only req0 -> OWN0. Only req1 -> OWN1.
  - Both -> the port that is not rr_last; rr_last updates to the winner.
  - Neither -> stay in IDLE.
  - The grant is visible the cycle after req. Strobes from a port are ignored until its gnt is 1.
- OWNx:
  - mem_rd=rdx&~wrx; mem_wr=wrx&~rdx; mem_addr=addrx; mem_din=dinx. These are combinational pass-through, zero added latency.
  - The other port's strobes are ignored; no error is raised for them.
  - reqx dropped:
    - Tag pipeline empty, other port requesting -> grant the other port next cycle; rr_last updates.
    - Tag pipeline empty, other port idle -> IDLE.
    - Reads still in flight -> DRAIN.
  - rdx&wrx in the same cycle -> no memory op, err=1, next state ERROR.
- DRAIN:
  - No strobes are forwarded.
  - Once the tag pipeline is empty, the IDLE arbitration rules apply in the same cycle.
- ERROR: absorbing; gnt0=gnt1=0; err=1. Left only by reset.
- Read return:
  - Each issued mem_rd pushes a valid tag {1, owner} into a MEM_LAT-deep shift register.
  - When the head tag is valid: dout<owner>=mem_dout and dvalid<owner>=1; the other port keeps dvalid=0.
  - Data for a port is delivered even after that port's grant has been released.
- Boundaries:
  - A write issued in the same cycle as a pending read return is legal.
  - MEM_LAT back-to-back reads keep the pipeline full; this is not an error.
  - Both ports hold req continuously -> ownership alternates only when the owner drops req. There is no preemption.

Optional Feature:
- Macro MEM_ARB_FIXED_PRIO_EN.
  - Defined: port 1 (data cache) always wins simultaneous requests, including at handover; rr_last is not implemented.
  - Undefined: round-robin as described above.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding constants IDLE=3'd0, OWN0=3'd1, OWN1=3'd2, DRAIN=3'd3, ERROR=3'd4;
  - the owner-tag width constant;
  - the default MEM_LAT.
- State is held in the codebase dff flop array.
- One sub-module, mem_arb_rdtag: the MEM_LAT-deep tag shift register with valid/owner and an empty flag.

Test Plan:
- Port 0 only: req0=1; then rd0 at addr0=16'h0010,0012,0014,0016 on consecutive cycles, MEM_LAT=2 -> gnt0 one cycle after req0; four mem_rd pulses; dvalid0 high 2 cycles after each; dout0 matches memory; dvalid1 stays 0.
- Simultaneous req0=req1=1 after reset -> OWN0 first. Port 0 drops req -> OWN1. Repeat with both requesting -> OWN0 again. With MEM_ARB_FIXED_PRIO_EN defined -> OWN1 both times.
- Port 1 issues a read, then drops req1 the next cycle while req0=1 -> DRAIN; gnt0 asserts only after dvalid1 delivers the data; mem_dout never routed to port 0.
- Port 0 asserts rd0=wr0=1 while owning -> no mem strobe; err=1 next cycle; state ERROR; gnt0=gnt1=0; stays in ERROR until rst=0, then recovers to IDLE.
- Reset mid-read: rst=0 one cycle after mem_rd -> no dvalid; all outputs 0; first request after release is granted normally.
- Write-back then fill: port 1 wr1 at 16'h0100 with din1=16'hBEEF, then rd1 at 16'h0200 -> mem_wr with mem_din=16'hBEEF, then mem_rd; dvalid1 at MEM_LAT; port 0 req held throughout is not granted until req1 drops.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data cache memory arbiter.
// MEM_ARB_FIXED_PRIO_EN (in mem_arbiter) selects fixed data-cache priority instead of round-robin.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        OWN0  = 3'd1,
        OWN1  = 3'd2,
        DRAIN = 3'd3,
        ERROR = 3'd4
    } arb_state_t;

    // Owner tag carried alongside each in-flight read: 0 = icache, 1 = dcache.
    localparam int OWNER_W     = 1;
    localparam int DEF_MEM_LAT = 2;

endpackage

// File: rtl/mem_arb_rdtag.sv
// Read-tag shift register: one stage per cycle of memory latency, head stage
// lines up with the cycle in which mem_dout carries the data for that read.
module mem_arb_rdtag
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = DEF_MEM_LAT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [OWNER_W-1:0] push_owner,
    output logic               head_valid,
    output logic [OWNER_W-1:0] head_owner,
    output logic               empty
);

    logic [DEPTH-1:0]   vld;
    logic [OWNER_W-1:0] own [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                own[i] <= '0;
            end
        end else begin
            vld[0] <= push;
            own[0] <= push_owner;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                own[i] <= own[i-1];
            end
        end
    end

    assign head_valid = vld[DEPTH-1];
    assign head_owner = own[DEPTH-1];
    assign empty      = ~|vld;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter granting whole transactions to the icache (port 0) or dcache (port 1).
// Define MEM_ARB_FIXED_PRIO_EN to give port 1 fixed priority; default is round-robin.
//
// state | meaning
// IDLE  | nobody owns memory, arbitrate pending requests
// OWN0  | port 0 owns memory, its strobes pass straight through
// OWN1  | port 1 owns memory, its strobes pass straight through
// DRAIN | owner released with reads in flight, wait for tag pipe to empty
// ERROR | rd and wr asserted together by the owner, held until reset
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = DEF_MEM_LAT,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          rd0,
    input  logic          wr0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] din0,
    output logic          gnt0,
    output logic [DW-1:0] dout0,
    output logic          dvalid0,
    input  logic          req1,
    input  logic          rd1,
    input  logic          wr1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] din1,
    output logic          gnt1,
    output logic [DW-1:0] dout1,
    output logic          dvalid1,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          err
);

    arb_state_t         state, next_state;
    logic               arb_en;
    logic               pick1;
    logic               drained;
    logic               tag_empty;
    logic               head_valid;
    logic [OWNER_W-1:0] head_owner;
    logic [OWNER_W-1:0] push_owner;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign pick1 = req1;
`else
    logic rr_last;

    // rr_last remembers the most recent winner so the other port wins the next tie.
    assign pick1 = req1 & (~req0 | ~rr_last);

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_last <= 1'b1;
        end else if (arb_en && (req0 || req1)) begin
            rr_last <= pick1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A read issued in the releasing cycle still counts as in flight.
    assign drained = tag_empty & ~mem_rd;

    always_comb begin
        next_state = state;
        arb_en     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_din    = '0;
        unique case (state)
            IDLE: arb_en = 1'b1;
            OWN0: begin
                if (rd0 && wr0) begin
                    next_state = ERROR;
                end else begin
                    mem_rd   = rd0;
                    mem_wr   = wr0;
                    mem_addr = addr0;
                    mem_din  = din0;
                    if (!req0) begin
                        if (tag_empty && !rd0) arb_en = 1'b1;
                        else                   next_state = DRAIN;
                    end
                end
            end
            OWN1: begin
                if (rd1 && wr1) begin
                    next_state = ERROR;
                end else begin
                    mem_rd   = rd1;
                    mem_wr   = wr1;
                    mem_addr = addr1;
                    mem_din  = din1;
                    if (!req1) begin
                        if (tag_empty && !rd1) arb_en = 1'b1;
                        else                   next_state = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drained) arb_en = 1'b1;
            end
            ERROR: next_state = ERROR;
            default: next_state = ERROR;
        endcase
        // The releasing port's req is already low, so handover reuses the idle rules.
        if (arb_en) begin
            if (req0 || req1) next_state = pick1 ? OWN1 : OWN0;
            else              next_state = IDLE;
        end
    end

    assign push_owner = (state == OWN1) ? 1'b1 : 1'b0;

    mem_arb_rdtag #(
        .DEPTH (MEM_LAT)
    ) u_rdtag (
        .clk        (clk),
        .rst        (rst),
        .push       (mem_rd),
        .push_owner (push_owner),
        .head_valid (head_valid),
        .head_owner (head_owner),
        .empty      (tag_empty)
    );

    assign dvalid0 = head_valid & (head_owner == 1'b0);
    assign dvalid1 = head_valid & (head_owner == 1'b1);
    assign dout0   = dvalid0 ? mem_dout : '0;
    assign dout1   = dvalid1 ? mem_dout : '0;

    assign gnt0 = (state == OWN0);
    assign gnt1 = (state == OWN1);
    assign err  = (state == ERROR);

endmodule
